uart_tx_fifo_reader: RTL



---
 rtl/uart_tx_fifo_reader_pkg.sv | 21 ++
 rtl/uart_tx_fifo_reader_baud_counter.sv | 30 +++
 rtl/uart_tx_fifo_reader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_reader_pkg.sv
// Shared UART definitions: state encodings, baud counter width and frame-length helper.
// Reused by the UART receiver.
package uart_tx_fifo_reader_pkg;

  localparam int BAUD_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  // Line cycles for one character, excluding the pop and fetch cycles.
  function automatic int frame_cycles(int data_width, int clks_per_bit, int stop_bits, bit parity);
    return (1 + data_width + int'(parity) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_reader_baud_counter.sv
// Baud counter shared by the UART transmitter and receiver: counts 0..CLKS_PER_BIT-1
// and pulses bit_done on the last cycle of each bit period.
module uart_baud_counter
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic restart,
  output logic bit_done
);

  localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;

  assign bit_done = !restart && (cnt_q == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining the TX FIFO read port; one frame per popped word.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_reader
  import uart_tx_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Enable_in,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  Fifo_Empty_in,
`ifdef UART_TX_PARITY_EN
  input  logic                  Parity_odd_in,
`endif
  output logic                  Fifo_ReadEn_out,
  output logic                  Tx_out,
  output logic                  Busy_out,
  output logic [2:0]            Dbg_state_out
);

  localparam int BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  bit_done;
  logic                  restart;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  // FIFO read handshake: a pop is a single-cycle Fifo_ReadEn_out pulse, only in IDLE
  // and only while Fifo_Empty_in is low; Fifo_Data_in is taken the following cycle.
  assign Fifo_ReadEn_out = pop;
  assign Busy_out        = (state_q != ST_IDLE) || pop;
  assign Tx_out          = tx_q;
  assign Dbg_state_out   = state_q;
  assign restart         = (state_q == ST_IDLE) || (state_q == ST_FETCH);

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .restart  (restart),
    .bit_done (bit_done)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Rst_n gate keeps the pop strobe low while reset is held.
        if (Enable_in && !Fifo_Empty_in && Rst_n) begin
          pop     = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        shift_d   = Fifo_Data_in;
        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
        parity_d  = (^Fifo_Data_in) ^ Parity_odd_in;
`endif
        state_d   = ST_START;
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == LAST_STOP) state_d = ST_IDLE;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the state being entered, so Tx_out tracks state_q.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

endmodule
